// File: rtl/vga_framebuffer_scanout.sv
// Pixel-plot frame buffer (X x Y x 3) scanned out as VGA with each stored pixel replicated 4x4.
// Pipeline: scan counters -> registered RAM read -> registered outputs (2 clocks latency).
module vga_framebuffer_scanout #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic [7:0] iX,
    input  logic [6:0] iY,
    input  logic [2:0] iColour,
    input  logic       iPlot,
    output logic [7:0] oVGA_R,
    output logic [7:0] oVGA_G,
    output logic [7:0] oVGA_B,
    output logic       oVGA_HS,
    output logic       oVGA_VS,
    output logic       oVGA_BLANK_N,
    output logic       oFrameStart
);
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int MEM_DEPTH = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);

    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

    localparam logic [7:0]        X_LIM    = 8'(X_SCREEN_PIXELS);
    localparam logic [6:0]        Y_LIM    = 7'(Y_SCREEN_PIXELS);
    localparam logic [ADDR_W-1:0] X_STRIDE = ADDR_W'(X_SCREEN_PIXELS);

    logic [2:0]        mem [MEM_DEPTH];
    logic [9:0]        hcount;
    logic [9:0]        vcount;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              vis0;
    logic              hs0;
    logic              vs0;
    logic              fs0;
    logic [2:0]        rd_data;
    logic              vis1;
    logic              hs1;
    logic              vs1;
    logic              fs1;

    // Write port: out-of-range coordinates and writes during reset are dropped.
    assign wr_en   = iPlot && !iReset && (iX < X_LIM) && (iY < Y_LIM);
    assign wr_addr = ADDR_W'(iY) * X_STRIDE + ADDR_W'(iX);

    always_ff @(posedge iClock) begin
        if (wr_en) begin
            mem[wr_addr] <= iColour;
        end
    end

    // Separate read process: a same-address write on the same edge returns the old colour.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    always_comb begin
        vis0    = (hcount < H_VIS) && (vcount < V_VIS);
        hs0     = !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
        vs0     = !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
        fs0     = (hcount == 10'd0) && (vcount == 10'd0);
        rd_addr = '0;
        if (vis0) begin
            rd_addr = ADDR_W'(vcount[9:2]) * X_STRIDE + ADDR_W'(hcount[9:2]);
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            vis1 <= 1'b0;
            hs1  <= 1'b1;
            vs1  <= 1'b1;
            fs1  <= 1'b0;
        end else begin
            vis1 <= vis0;
            hs1  <= hs0;
            vs1  <= vs0;
            fs1  <= fs0;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_HS      <= 1'b1;
            oVGA_VS      <= 1'b1;
            oVGA_BLANK_N <= 1'b0;
            oFrameStart  <= 1'b0;
        end else begin
            oVGA_R       <= {8{rd_data[2] & vis1}};
            oVGA_G       <= {8{rd_data[1] & vis1}};
            oVGA_B       <= {8{rd_data[0] & vis1}};
            oVGA_HS      <= hs1;
            oVGA_VS      <= vs1;
            oVGA_BLANK_N <= vis1;
            oFrameStart  <= fs1;
        end
    end

endmodule

// File: doc/vga_framebuffer_scanout.md
# vga_framebuffer_scanout

Receiving end of the pixel-plot interface driven by the box/clear drawing engine. It accepts single-pixel writes (X, Y, colour, plot strobe) into an on-chip 160x120x3 frame buffer and continuously scans the buffer out as 640x480 VGA, each stored pixel replicated 4x4. It sits between the drawing FSM/datapath and the board DAC pins and shares the drawing engine's clock, which is the 25 MHz pixel clock.

## Interface
Parameters:
- X_SCREEN_PIXELS, 160, frame buffer width (stored pixels)
- Y_SCREEN_PIXELS, 120, frame buffer height
- H_VISIBLE / H_FRONT / H_SYNC / H_BACK, 640 / 16 / 96 / 48, horizontal timing in clocks (total 800)
- V_VISIBLE / V_FRONT / V_SYNC / V_BACK, 480 / 10 / 2 / 33, vertical timing in lines (total 525)

Ports:
- iClock  in  1  pixel clock, all logic on rising edge
- iReset  in  1  synchronous, active-high reset
- iX  in  8  write X coordinate, 0..159
- iY  in  7  write Y coordinate, 0..119
- iColour  in  3  write colour {R,G,B}
- iPlot  in  1  write enable, one pixel per cycle while high
- oVGA_R / oVGA_G / oVGA_B  out  8 each  colour outputs, each is 8'hFF if the bit is set, else 8'h00
- oVGA_HS  out  1  horizontal sync, active low
- oVGA_VS  out  1  vertical sync, active low
- oVGA_BLANK_N  out  1  high only in the visible region
- oFrameStart  out  1  one-cycle pulse aligned with the first visible pixel of each frame

## Operation
- **Write port**
  - On each edge with iPlot=1, iX<160 and iY<120: mem[iY*160+iX] <= iColour.
  - Out-of-range coordinates are ignored and leave the memory unchanged.
  - No backpressure: every cycle can carry a write.
- **Memory**
  - 19200 x 3 bits with one write port and one registered read port (inferred block RAM).
  - Read-during-write to the same address returns the old data.
  - Memory contents are not affected by iReset; the drawing engine's clear pass handles that.
- **Scan counters**
  - hcount 10 bits, runs 0..799, then wraps to 0 and increments vcount.
  - vcount 10 bits, runs 0..524, then wraps to 0.
- **Stage 0 (counters)**
  - read address = (vcount>>2)*160 + (hcount>>2), computed only when visible (hcount<640, vcount<480); otherwise 0.
  - visible = hcount<640 && vcount<480.
  - hs = !(656<=hcount<752).
  - vs = !(490<=vcount<492).
  - fs = (hcount==0 && vcount==0).
- **Stage 1 (memory read)**
  - RAM data is registered.
  - visible, hs, vs and fs are delayed one register to match.
- **Stage 2 (output registers)**
  - Colour outputs are expanded from the RAM data and gated to 0 when not visible.
  - Sync, blank and frame-start outputs are registered.
- All outputs are registered. There is no combinational path from any input to any output.

## Timing
- Pipeline latency is 2 clocks: outputs in the cycle after edge N reflect the counter values present before edge N-1.
- A write at edge W is visible to a scan read issued at edge W+1 or later.
- **Reset** (iReset=1 at an edge):
  - hcount=vcount=0 and all pipeline registers clear.
  - Outputs: RGB=0, HS=1, VS=1, BLANK_N=0, oFrameStart=0.
  - Writes presented during reset are ignored.
- **After reset release:**
  - The first edge with iReset=0 advances the counters to hcount=1.
  - oFrameStart first pulses when counter (0,0) reaches the outputs. Because reset leaves the counters at (0,0), this is 2 edges after release.
  - BLANK_N goes high in the same cycle as that pulse.
- **Line and frame periods:**
  - HS is low for 96 clocks, repeating every 800 clocks.
  - VS is low for 1600 clocks (2 lines), repeating every 420000 clocks.
  - BLANK_N is high for 640 clocks per line on 480 lines.
- Reset asserted mid-frame takes effect at the next edge. The scan restarts from (0,0) with no partial-line glitch beyond a shortened line.
- A write and a read of the same address on the same edge: the scan sees the old colour and the new colour appears from the next frame.

## Test plan
- Reset: hold iReset 3 cycles mid-line with iPlot=1, iX=0, iY=0, iColour=3'b111.
  - Outputs must be RGB=0, HS=VS=1, BLANK_N=0.
  - The pixel stays unwritten: (0,0) outputs RGB=0 in the next frame, given memory preloaded to 0.
  - oFrameStart pulses exactly 2 edges after release.
- Timing: run 2 full frames and measure.
  - HS low 96, period 800.
  - VS low 1600, period 420000.
  - BLANK_N high 640 clocks per line on 480 lines.
  - HS falls 656 clocks after the BLANK_N rise.
- Single write: plot (5,3) with colour 3'b100.
  - Next frame: R=8'hFF, G=B=0 for screen x 20..23 on lines 12..15.
  - All 16 output pixels show this.
  - Neighbouring screen pixels are unchanged.
- Out-of-range writes: plot (160,0) and (0,120) with colour 3'b010.
  - No memory location changes.
  - A full-frame compare against the expected image passes.
- Burst: 16 back-to-back writes of a 4x4 box at (10,10) with colour 3'b001, as the drawing engine produces it.
  - All 16 cells read back blue.
  - This gives a 16x16 blue block at screen (40..55, 40..55).
- Same-cycle collision: write (0,0) with 3'b010 on the exact edge its scan read issues.
  - The current frame shows the old colour.
  - The following frame shows G=8'hFF.
